// File: rtl/code_decoder_if.sv
// Handshake and status bundle between a code producer and code_decoder.
// The producer side uses the master modport; the decoder uses slave.
interface code_decoder_if #(
    parameter int DEPTH = 4
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [2:0]    in_code;
    logic          in_ready;
    logic [7:0]    out;
    logic          out_valid;
    logic [FW-1:0] fill;
    logic          overflow;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  out,
        input  out_valid,
        input  fill,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output out,
        output out_valid,
        output fill,
        output overflow
    );
endinterface

// File: rtl/code_decoder.sv
// Buffered 3-to-8 decoder: queues 3-bit codes and replays each as a one-hot
// pulse held for HOLD cycles, followed by a one-cycle all-zero gap.
module code_decoder #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    code_decoder_if.slave  bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam int            FW        = AW + 1;
    localparam logic [FW-1:0] FULL      = FW'(DEPTH);
    localparam logic [7:0]    HOLD_LOAD = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] fill_q;
    logic [7:0]    cnt;
    logic [7:0]    cnt_n;
    logic [7:0]    out_q;
    logic [7:0]    out_n;
    logic          out_valid_q;
    logic          overflow_q;
    logic          ready;
    logic          empty;
    logic          push;
    logic          pop;

    // Readiness looks only at the registered count, so a same-edge pop never frees a slot.
    assign ready = (fill_q != FULL);
    assign empty = (fill_q == '0);
    assign push  = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
            if (bus.in_valid && !ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            out_q       <= out_n;
            out_valid_q <= (out_n != 8'h00);
        end
    end

    // IDLE and GAP share the load path; only an empty FIFO distinguishes where they go.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out_q;
        pop     = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    out_n   = 8'h01 << mem[rd_ptr];
                    cnt_n   = HOLD_LOAD;
                    state_n = DRIVE;
                end else begin
                    out_n   = 8'h00;
                    state_n = IDLE;
                end
            end
            DRIVE: begin
                if (cnt == 8'h00) begin
                    out_n   = 8'h00;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 8'h01;
                end
            end
            default: begin
                out_n   = 8'h00;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fill      = fill_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_code_decoder.sv
// Directed bench for code_decoder: three instances (HOLD 2, 4, 1) share clk/rst_n;
// a negedge monitor scores each pulse against codes the bench expects to be accepted.
module tb_code_decoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];
    logic [7:0] prev [3];
    int         run  [3];
    int         holds[3] = '{2, 4, 1};

    always #5 clk = ~clk;

    code_decoder_if #(.DEPTH(4)) ifa ();
    code_decoder_if #(.DEPTH(4)) ifb ();
    code_decoder_if #(.DEPTH(4)) ifc ();

    code_decoder #(.DEPTH(4), .HOLD(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    code_decoder #(.DEPTH(4), .HOLD(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    code_decoder #(.DEPTH(4), .HOLD(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [2:0] code, input logic accept);
        logic       rdy;
        logic [7:0] one;
        one = 8'h01;
        rdy = 1'b0;
        case (idx)
            0: begin ifa.in_valid = v; ifa.in_code = code; rdy = ifa.in_ready; end
            1: begin ifb.in_valid = v; ifb.in_code = code; rdy = ifb.in_ready; end
            default: begin ifc.in_valid = v; ifc.in_code = code; rdy = ifc.in_ready; end
        endcase
        if (v) begin
            checkOutput($sformatf("in_ready[%0d]", idx), rdy, accept);
            if (accept) begin
                case (idx)
                    0: qa.push_back(one << code);
                    1: qb.push_back(one << code);
                    default: qc.push_back(one << code);
                endcase
            end
        end
    endtask

    task automatic expectState(input int idx, input logic [7:0] eo, input logic [2:0] ef, input logic eovf);
        logic [7:0] o;
        logic       ov;
        logic [2:0] f;
        logic       ovf;
        logic       rdy;
        case (idx)
            0: begin o = ifa.out; ov = ifa.out_valid; f = ifa.fill; ovf = ifa.overflow; rdy = ifa.in_ready; end
            1: begin o = ifb.out; ov = ifb.out_valid; f = ifb.fill; ovf = ifb.overflow; rdy = ifb.in_ready; end
            default: begin o = ifc.out; ov = ifc.out_valid; f = ifc.fill; ovf = ifc.overflow; rdy = ifc.in_ready; end
        endcase
        checkOutput($sformatf("out[%0d]", idx), o, eo);
        checkOutput($sformatf("out_valid[%0d]", idx), ov, eo != 8'h00);
        checkOutput($sformatf("fill[%0d]", idx), f, ef);
        checkOutput($sformatf("overflow[%0d]", idx), ovf, eovf);
        checkOutput($sformatf("in_ready_lvl[%0d]", idx), rdy, ef != 3'd4);
    endtask

    task automatic monitor(input int idx, input logic [7:0] o, input logic ov);
        logic [7:0] exp_code;
        int         qsize;
        checkOutput($sformatf("valid_vs_out[%0d]", idx), ov, o != 8'h00);
        if (o != 8'h00) begin
            if (prev[idx] == 8'h00) begin
                case (idx)
                    0: qsize = qa.size();
                    1: qsize = qb.size();
                    default: qsize = qc.size();
                endcase
                if (qsize == 0) begin
                    checkOutput($sformatf("unexpected_pulse[%0d]", idx), o, 8'h00);
                end else begin
                    case (idx)
                        0: exp_code = qa.pop_front();
                        1: exp_code = qb.pop_front();
                        default: exp_code = qc.pop_front();
                    endcase
                    checkOutput($sformatf("pulse_code[%0d]", idx), o, exp_code);
                end
                run[idx] = 1;
            end else begin
                checkOutput($sformatf("pulse_steady[%0d]", idx), o, prev[idx]);
                run[idx]++;
            end
        end else if (prev[idx] != 8'h00) begin
            checkOutput($sformatf("pulse_width[%0d]", idx), run[idx], holds[idx]);
        end
        prev[idx] = o;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                prev[k] = 8'h00;
                run[k]  = 0;
            end
        end else begin
            monitor(0, ifa.out, ifa.out_valid);
            monitor(1, ifb.out, ifb.out_valid);
            monitor(2, ifc.out, ifc.out_valid);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] one;
        logic [7:0] expv;
        one = 8'h01;
        ifa.in_valid = 1'b0; ifa.in_code = 3'd0;
        ifb.in_valid = 1'b0; ifb.in_code = 3'd0;
        ifc.in_valid = 1'b0; ifc.in_code = 3'd0;
        repeat (3) cycle();
        rst_n = 1'b1;
        expectState(0, 8'h00, 3'd0, 1'b0);
        expectState(1, 8'h00, 3'd0, 1'b0);
        expectState(2, 8'h00, 3'd0, 1'b0);

        // Single code 5 with HOLD=2
        applyStimulus(0, 1'b1, 3'd5, 1'b1); cycle();
        applyStimulus(0, 1'b0, 3'd0, 1'b0); expectState(0, 8'h00, 3'd1, 1'b0);
        cycle(); expectState(0, 8'h20, 3'd0, 1'b0);
        cycle(); expectState(0, 8'h20, 3'd0, 1'b0);
        cycle(); expectState(0, 8'h00, 3'd0, 1'b0);
        repeat (2) cycle();

        // Burst 0,7,3 with HOLD=2
        applyStimulus(0, 1'b1, 3'd0, 1'b1); cycle();
        expectState(0, 8'h00, 3'd1, 1'b0);
        applyStimulus(0, 1'b1, 3'd7, 1'b1); cycle();
        expectState(0, 8'h01, 3'd1, 1'b0);
        applyStimulus(0, 1'b1, 3'd3, 1'b1); cycle();
        expectState(0, 8'h01, 3'd2, 1'b0);
        applyStimulus(0, 1'b0, 3'd0, 1'b0); cycle();
        expectState(0, 8'h00, 3'd2, 1'b0);
        cycle(); expectState(0, 8'h80, 3'd1, 1'b0);
        repeat (2) cycle(); expectState(0, 8'h00, 3'd1, 1'b0);
        cycle(); expectState(0, 8'h08, 3'd0, 1'b0);
        repeat (3) cycle(); expectState(0, 8'h00, 3'd0, 1'b0);
        checkOutput("drained_a", qa.size(), 0);

        // Fill DEPTH=4 with HOLD=4, then overflow, then refused push on a popping edge
        applyStimulus(1, 1'b1, 3'd1, 1'b1); cycle();
        applyStimulus(1, 1'b1, 3'd2, 1'b1); cycle();
        expectState(1, 8'h02, 3'd1, 1'b0);
        applyStimulus(1, 1'b1, 3'd3, 1'b1); cycle();
        applyStimulus(1, 1'b1, 3'd4, 1'b1); cycle();
        applyStimulus(1, 1'b1, 3'd6, 1'b1); cycle();
        expectState(1, 8'h02, 3'd4, 1'b0);
        applyStimulus(1, 1'b1, 3'd7, 1'b0); cycle();
        expectState(1, 8'h00, 3'd4, 1'b1);
        applyStimulus(1, 1'b1, 3'd7, 1'b0); cycle();
        expectState(1, 8'h04, 3'd3, 1'b1);
        applyStimulus(1, 1'b0, 3'd0, 1'b0);
        repeat (22) cycle();
        expectState(1, 8'h00, 3'd0, 1'b1);
        checkOutput("drained_b", qb.size(), 0);

        // Asynchronous reset in the middle of a pulse with three codes queued
        applyStimulus(1, 1'b1, 3'd1, 1'b1); cycle();
        applyStimulus(1, 1'b1, 3'd2, 1'b1); cycle();
        applyStimulus(1, 1'b1, 3'd3, 1'b1); cycle();
        applyStimulus(1, 1'b1, 3'd4, 1'b1); cycle();
        applyStimulus(1, 1'b0, 3'd0, 1'b0);
        expectState(1, 8'h02, 3'd3, 1'b1);
        rst_n = 1'b0;
        #1;
        expectState(1, 8'h00, 3'd0, 1'b0);
        qa.delete(); qb.delete(); qc.delete();
        cycle();
        rst_n = 1'b1;
        repeat (20) cycle();
        expectState(1, 8'h00, 3'd0, 1'b0);

        // Every code with HOLD=1
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2, 1'b1, i[2:0], 1'b1); cycle();
            applyStimulus(2, 1'b0, 3'd0, 1'b0);
            expectState(2, 8'h00, 3'd1, 1'b0);
            cycle();
            expv = one << i;
            expectState(2, expv, 3'd0, 1'b0);
        end
        cycle(); expectState(2, 8'h00, 3'd0, 1'b0);
        checkOutput("drained_c", qc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/code_decoder.md
# code_decoder

Buffered 3-to-8 decoder: the inverse of the team's 8-to-3 priority encoder. Accepts 3-bit codes over a valid/ready handshake, queues them in a small FIFO, and replays each as a one-hot 8-bit output pulse of programmable width. Each pulse is followed by a one-cycle all-zero gap. Used on the consumer side of encoder links to regenerate one-hot request/select lines.

## Interface

Parameters
- `DEPTH`, default 4: FIFO entries; power of two, 2 to 16.
- `HOLD`, default 2: cycles each one-hot output is held; valid range 1 to 255.

Ports
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_code` is offered.
- `in_code`, input, 3: code to decode; value n selects `out[n]`.
- `in_ready`, output, 1: FIFO can accept.
- `out`, output, 8: registered one-hot decode; all-zero when not driving.
- `out_valid`, output, 1: high exactly while `out` is non-zero.
- `fill`, output, clog2(DEPTH)+1: registered count of queued codes, excluding the one being driven.
- `overflow`, output, 1: sticky; set by `in_valid` while `in_ready` is low; cleared only by reset.

## Operation

- Push: a code is accepted on any rising edge where `in_valid && in_ready`.
- `in_ready` = (`fill` != DEPTH), derived from registered `fill` only. A pop in the same cycle does not open a slot when full.
- `in_valid` while `in_ready` is low:
  - the code is dropped;
  - `overflow` sets on that edge;
  - FIFO state is unchanged.
- FSM states:
  - IDLE: `out`=0. If FIFO is non-empty, pop the head, load `out` with one-hot(head), set hold counter to HOLD-1, and go to DRIVE.
  - DRIVE: `out` is held. If the counter is 0, clear `out` and go to GAP. Otherwise decrement the counter.
  - GAP: `out`=0 for exactly one cycle. If FIFO is non-empty, pop and go to DRIVE (same load as IDLE). Otherwise go to IDLE.
- A push and a pop on the same edge leave `fill` unchanged and must not corrupt the FIFO. The pushed entry is queued behind existing entries.
- FIFO read/write pointers wrap modulo DEPTH. The extra `fill` bit distinguishes full from empty.
- The decode is a pure shift: `out` = 8'b1 << code. Every code 0 to 7 is legal. There is no invalid-code case.
- `out_valid` is registered in lockstep with `out`. It never differs from (`out` != 0).

## Timing

- Reset (asynchronous assert, synchronous release) forces:
  - `out`=0, `out_valid`=0, `fill`=0, `overflow`=0, `in_ready`=1;
  - state IDLE, pointers 0.
- Reset asserted mid-pulse clears `out` immediately and discards all queued codes.
- Latency, code pushed at edge k into an empty block in IDLE:
  - `fill`=1 during cycle k+1;
  - pop at edge k+1;
  - `out` is one-hot from edge k+1 through edge k+1+HOLD;
  - `fill` returns to 0 at edge k+1.
- Back-to-back throughput: one code every HOLD+1 cycles (HOLD drive cycles plus 1 gap).
- `out` changes only on clock edges, except for asynchronous reset.

## Test plan

- Reset, then push code 5 at edge 1 (HOLD=2) -> `out`=8'b0010_0000 and `out_valid`=1 after edges 2 and 3; `out`=0 after edge 4; `fill` 1→0.
- Burst of codes 0,7,3 on consecutive edges (HOLD=2) -> outputs 8'h01, 8'h80, 8'h08, each for 2 cycles with a 1-cycle zero gap between; `fill` peaks at 2.
- Push 5 codes back-to-back with DEPTH=4, HOLD=4 -> first pops immediately, next 4 fill the FIFO; `in_ready`=0 at `fill`=4; a 6th `in_valid` sets `overflow` and that code never appears on `out`.
- Full FIFO with a pop on the same edge as `in_valid` -> push refused (`in_ready` was 0), `overflow`=1, `fill` drops to 3.
- Assert `rst_n`=0 mid-DRIVE with 3 queued codes -> `out`=0 and `fill`=0 without a clock edge; after release, no stale codes are emitted.
- Exhaustive: each code 0 to 7, HOLD=1 -> `out` is 1<<code for exactly 1 cycle, period 2 cycles, `out_valid` == |`out` every cycle.
